// File: rtl/dcpu16_arb_pkg.sv
// Shared encodings for the DCPU16 fetch/data-bus memory arbiter.
// The timeout constants matter only in builds with DCPU16_ARB_TMO_EN.
package dcpu16_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_FS = 2'd1,
        GNT_AB = 2'd2
    } arb_state_e;

    localparam logic REQ_FS = 1'b0;
    localparam logic REQ_AB = 1'b1;

    localparam logic [15:0] ARB_TMO_FILL = 16'h0000;
    localparam int          ARB_TMO_DEF  = 16;

    function automatic arb_state_e gnt_state(input logic req);
        return (req == REQ_AB) ? GNT_AB : GNT_FS;
    endfunction

endpackage

// File: rtl/dcpu16_mem_arb_if.sv
// Strobe/ack bus used three times around the arbiter: fs, ab and mem.
// The requester side is the master; the responding side is the slave.
interface dcpu16_mem_arb_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          stb;
    logic          wre;
    logic [AW-1:0] adr;
    logic [DW-1:0] dto;
    logic [DW-1:0] dti;
    logic          ack;

    modport master (output stb, wre, adr, dto, input dti, ack);
    modport slave  (input stb, wre, adr, dto, output dti, ack);
endinterface

// File: rtl/dcpu16_arb_tmo.sv
// Ack-timeout watchdog for the arbiter, built only with DCPU16_ARB_TMO_EN.
// Raises o_tmo in the TMO-th cycle of a grant that has seen no mem ack.
module dcpu16_arb_tmo #(
    parameter int TMO = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_grant,
    input  logic i_load,
    input  logic i_mem_ack,
    output logic o_tmo,
    output logic o_err
);
    localparam logic [7:0] CNT_LAST = 8'(TMO - 1);

    logic [7:0] r_cnt;
    logic       r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 8'd0;
            r_err <= 1'b0;
        end else begin
            // A new grant (including a direct hand-over) restarts the count
            if (i_load || !i_grant) begin
                r_cnt <= 8'd0;
            end else if (!i_mem_ack) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (o_tmo) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_tmo = i_grant && !i_mem_ack && (r_cnt == CNT_LAST);
    assign o_err = r_err;

endmodule

// File: rtl/dcpu16_mem_arb.sv
// Round-robin arbiter sharing one single-port memory between the DCPU16
// fetch bus (fs) and data bus (ab). DCPU16_ARB_TMO_EN adds an ack timeout.
module dcpu16_mem_arb
    import dcpu16_arb_pkg::*;
#(
    parameter int AW  = 16,
    parameter int DW  = 16,
    parameter int TMO = ARB_TMO_DEF
) (
    input  logic               clk,
    input  logic               rst,
    dcpu16_mem_arb_if.slave    fs,
    dcpu16_mem_arb_if.slave    ab,
    dcpu16_mem_arb_if.master   mem,
    output logic               arb_err
);
    arb_state_e    r_state;
    arb_state_e    w_state_next;
    logic          r_lst;
    logic          w_lst_next;
    logic          r_mem_stb;
    logic          w_mem_stb_next;
    logic          r_mem_wre;
    logic [AW-1:0] r_mem_adr;
    logic [DW-1:0] r_mem_dto;

    logic          w_load;
    logic          w_sel;
    logic          w_tmo;
    logic          w_done;
    logic          w_ld_wre;
    logic [AW-1:0] w_ld_adr;
    logic [DW-1:0] w_ld_dto;
    logic [DW-1:0] w_dti;

    assign w_done = (r_state != IDLE) && (mem.ack || w_tmo);

    always_comb begin
        w_state_next   = r_state;
        w_lst_next     = r_lst;
        w_mem_stb_next = r_mem_stb;
        w_load         = 1'b0;
        w_sel          = REQ_FS;
        case (r_state)
            IDLE: begin
                if (fs.stb && ab.stb) begin
                    w_load = 1'b1;
                    w_sel  = (r_lst == REQ_AB) ? REQ_FS : REQ_AB;
                end else if (fs.stb) begin
                    w_load = 1'b1;
                    w_sel  = REQ_FS;
                end else if (ab.stb) begin
                    w_load = 1'b1;
                    w_sel  = REQ_AB;
                end
            end
            // The served requester's stb is still high here, so only the
            // other side may be granted on the completion edge.
            GNT_FS: begin
                if (w_done) begin
                    w_lst_next = REQ_FS;
                    if (ab.stb) begin
                        w_load = 1'b1;
                        w_sel  = REQ_AB;
                    end else begin
                        w_state_next   = IDLE;
                        w_mem_stb_next = 1'b0;
                    end
                end
            end
            GNT_AB: begin
                if (w_done) begin
                    w_lst_next = REQ_AB;
                    if (fs.stb) begin
                        w_load = 1'b1;
                        w_sel  = REQ_FS;
                    end else begin
                        w_state_next   = IDLE;
                        w_mem_stb_next = 1'b0;
                    end
                end
            end
            default: begin
                w_state_next   = IDLE;
                w_mem_stb_next = 1'b0;
            end
        endcase
        if (w_load) begin
            w_state_next   = gnt_state(w_sel);
            w_mem_stb_next = 1'b1;
        end
    end

    assign w_ld_wre = (w_sel == REQ_AB) ? ab.wre : fs.wre;
    assign w_ld_adr = (w_sel == REQ_AB) ? ab.adr : fs.adr;
    assign w_ld_dto = (w_sel == REQ_AB) ? ab.dto : fs.dto;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_lst     <= REQ_AB;
            r_mem_stb <= 1'b0;
            r_mem_wre <= 1'b0;
            r_mem_adr <= '0;
            r_mem_dto <= '0;
        end else begin
            r_state   <= w_state_next;
            r_lst     <= w_lst_next;
            r_mem_stb <= w_mem_stb_next;
            if (w_load) begin
                r_mem_wre <= w_ld_wre;
                r_mem_adr <= w_ld_adr;
                r_mem_dto <= w_ld_dto;
            end
        end
    end

    assign mem.stb = r_mem_stb;
    assign mem.wre = r_mem_wre;
    assign mem.adr = r_mem_adr;
    assign mem.dto = r_mem_dto;

    // A forced timeout ack returns the fill pattern instead of memory data
    assign w_dti  = w_tmo ? DW'(ARB_TMO_FILL) : mem.dti;
    assign fs.dti = w_dti;
    assign ab.dti = w_dti;
    assign fs.ack = (r_state == GNT_FS) && (mem.ack || w_tmo);
    assign ab.ack = (r_state == GNT_AB) && (mem.ack || w_tmo);

`ifdef DCPU16_ARB_TMO_EN
    dcpu16_arb_tmo #(
        .TMO(TMO)
    ) u_tmo (
        .clk       (clk),
        .rst       (rst),
        .i_grant   (r_state != IDLE),
        .i_load    (w_load),
        .i_mem_ack (mem.ack),
        .o_tmo     (w_tmo),
        .o_err     (arb_err)
    );
`else
    assign w_tmo   = 1'b0;
    assign arb_err = 1'b0;
`endif

endmodule

// File: tb/tb_dcpu16_mem_arb.sv
// Bench for dcpu16_mem_arb: cycle vector table plus round-robin, reset and
// (with DCPU16_ARB_TMO_EN, TMO=4) timeout sequences.
module tb_dcpu16_mem_arb;
    import dcpu16_arb_pkg::*;

`ifdef DCPU16_ARB_TMO_EN
    localparam int TB_TMO = 4;
`else
    localparam int TB_TMO = 16;
`endif

    logic clk = 1'b0;
    logic rst;
    logic arb_err;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    dcpu16_mem_arb_if #(.AW(16), .DW(16)) fs_if ();
    dcpu16_mem_arb_if #(.AW(16), .DW(16)) ab_if ();
    dcpu16_mem_arb_if #(.AW(16), .DW(16)) mem_if ();

    dcpu16_mem_arb #(.AW(16), .DW(16), .TMO(TB_TMO)) dut (
        .clk     (clk),
        .rst     (rst),
        .fs      (fs_if),
        .ab      (ab_if),
        .mem     (mem_if),
        .arb_err (arb_err)
    );

    // Memory model: acks one cycle after seeing stb, contents A000+index
    logic [15:0] mem_arr [16];
    logic        mem_en = 1'b1;
    logic        r_mack = 1'b0;
    logic [15:0] r_mdti = 16'h0;
    assign mem_if.ack = r_mack;
    assign mem_if.dti = r_mdti;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) mem_arr[i] <= 16'hA000 | 16'(i);
            mem_arr[0] <= 16'h7C01;
            r_mack <= 1'b0;
        end else if (mem_en && mem_if.stb && !r_mack) begin
            r_mack <= 1'b1;
            if (mem_if.wre) begin
                mem_arr[mem_if.adr[3:0]] <= mem_if.dto;
                r_mdti <= mem_if.dto;
            end else begin
                r_mdti <= mem_arr[mem_if.adr[3:0]];
            end
        end else begin
            r_mack <= 1'b0;
        end
    end

    typedef struct {
        logic        rst;
        logic        fs_stb;
        logic        fs_wre;
        logic [15:0] fs_adr;
        logic [15:0] fs_dto;
        logic        ab_stb;
        logic        ab_wre;
        logic [15:0] ab_adr;
        logic [15:0] ab_dto;
        logic        e_mem_stb;
        logic        chk_mem;
        logic        e_mem_wre;
        logic [15:0] e_mem_adr;
        logic [15:0] e_mem_dto;
        logic        e_fs_ack;
        logic        e_ab_ack;
        logic [15:0] e_dti;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        fs_if.stb = 1'b0; fs_if.wre = 1'b0; fs_if.adr = 16'h0; fs_if.dto = 16'h0;
        ab_if.stb = 1'b0; ab_if.wre = 1'b0; ab_if.adr = 16'h0; ab_if.dto = 16'h0;
    endtask

    initial begin
        int   n_fs;
        int   n_ab;
        int   n_tot;
        int   tmo_cyc;
        vec_t v;

        rst = 1'b1;
        drive_idle();

        // rst, fs, fs_wre, fs_adr, fs_dto, ab, ab_wre, ab_adr, ab_dto | mem_stb, chk_mem, wre, adr, dto, fs_ack, ab_ack, dti
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'h0000};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, 1'b0, 16'h7C01};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 16'h0021, 16'h0000, 1'b1, 1'b0, 16'h0032, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0021, 16'h0000, 1'b0, 1'b0, 16'h0000};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 16'h0021, 16'h0000, 1'b1, 1'b0, 16'h0032, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0021, 16'h0000, 1'b1, 1'b0, 16'hA001};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 16'h0021, 16'h0000, 1'b1, 1'b0, 16'h0032, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0032, 16'h0000, 1'b0, 1'b0, 16'h0000};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0032, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0032, 16'h0000, 1'b0, 1'b1, 16'hA002};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0032, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h1234, 16'hBEEF, 1'b1, 1'b1, 1'b1, 16'h1234, 16'hBEEF, 1'b0, 1'b0, 16'h0000};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h1234, 16'hBEEF, 1'b1, 1'b1, 1'b1, 16'h1234, 16'hBEEF, 1'b0, 1'b1, 16'hBEEF};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h1234, 16'hBEEF, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 16'h1234, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h1234, 16'h0000, 1'b0, 1'b0, 16'h0000};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 16'h1234, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h1234, 16'h0000, 1'b1, 1'b0, 16'hBEEF};
        vecs[17] = '{1'b0, 1'b1, 1'b0, 16'h1234, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000};
        vecs[18] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000};

        for (int i = 0; i < NV; i++) begin
            v = vecs[i];
            rst       = v.rst;
            fs_if.stb = v.fs_stb; fs_if.wre = v.fs_wre; fs_if.adr = v.fs_adr; fs_if.dto = v.fs_dto;
            ab_if.stb = v.ab_stb; ab_if.wre = v.ab_wre; ab_if.adr = v.ab_adr; ab_if.dto = v.ab_dto;
            step();
            chk($sformatf("v%0d mem_stb", i), 32'(mem_if.stb), 32'(v.e_mem_stb));
            chk($sformatf("v%0d fs_ack", i), 32'(fs_if.ack), 32'(v.e_fs_ack));
            chk($sformatf("v%0d ab_ack", i), 32'(ab_if.ack), 32'(v.e_ab_ack));
            if (v.chk_mem) begin
                chk($sformatf("v%0d mem_wre", i), 32'(mem_if.wre), 32'(v.e_mem_wre));
                chk($sformatf("v%0d mem_adr", i), 32'(mem_if.adr), 32'(v.e_mem_adr));
                chk($sformatf("v%0d mem_dto", i), 32'(mem_if.dto), 32'(v.e_mem_dto));
            end
            if (v.e_fs_ack) chk($sformatf("v%0d fs_dti", i), 32'(fs_if.dti), 32'(v.e_dti));
            if (v.e_ab_ack) chk($sformatf("v%0d ab_dti", i), 32'(ab_if.dti), 32'(v.e_dti));
            if (i == 0) chk("reset arb_err", 32'(arb_err), 32'd0);
            $display("vec %0d: mem_stb=%b adr=%h fs_ack=%b ab_ack=%b dti=%h", i,
                     mem_if.stb, mem_if.adr, fs_if.ack, ab_if.ack, fs_if.dti);
        end

        // Both requesters held: strict alternation starting with FS after reset
        rst = 1'b1;
        drive_idle();
        step();
        rst = 1'b0;
        fs_if.stb = 1'b1; fs_if.adr = 16'h0003;
        ab_if.stb = 1'b1; ab_if.adr = 16'h0005;
        n_fs = 0; n_ab = 0; n_tot = 0;
        for (int c = 0; c < 40 && n_tot < 8; c++) begin
            step();
            if (fs_if.ack && ab_if.ack) chk("rr both acks", 32'd1, 32'd0);
            if (fs_if.ack || ab_if.ack) begin
                chk($sformatf("rr order %0d", n_tot), 32'(ab_if.ack), 32'(n_tot % 2));
                if (fs_if.ack) begin
                    chk($sformatf("rr fs_dti %0d", n_tot), 32'(fs_if.dti), 32'h0000A003);
                    n_fs++;
                end else begin
                    chk($sformatf("rr ab_dti %0d", n_tot), 32'(ab_if.dti), 32'h0000A005);
                    n_ab++;
                end
                $display("rr txn %0d: %s", n_tot, fs_if.ack ? "FS" : "AB");
                n_tot++;
            end
        end
        chk("rr fs count", 32'(n_fs), 32'd4);
        chk("rr ab count", 32'(n_ab), 32'd4);
        drive_idle();
        step();
        chk("rr idle mem_stb", 32'(mem_if.stb), 32'd0);

        // Reset while GNT_AB waits for an ack that never comes
        mem_en = 1'b0;
        ab_if.stb = 1'b1; ab_if.adr = 16'h0040;
        step();
        chk("rst-mid grant state", 32'(dut.r_state), 32'(GNT_AB));
        chk("rst-mid grant mem_stb", 32'(mem_if.stb), 32'd1);
        rst = 1'b1;
        step();
        chk("rst-mid mem_stb", 32'(mem_if.stb), 32'd0);
        chk("rst-mid state", 32'(dut.r_state), 32'(IDLE));
        chk("rst-mid ab_ack", 32'(ab_if.ack), 32'd0);
        chk("rst-mid arb_err", 32'(arb_err), 32'd0);
        rst = 1'b0;
        ab_if.stb = 1'b0;
        step();
        chk("rst-post ab_ack", 32'(ab_if.ack), 32'd0);
        $display("rst-mid: mem_stb=%b ab_ack=%b arb_err=%b", mem_if.stb, ab_if.ack, arb_err);

`ifdef DCPU16_ARB_TMO_EN
        // Memory silent: forced ack in the 4th grant cycle, sticky error
        fs_if.stb = 1'b1; fs_if.adr = 16'h0050;
        tmo_cyc = 0;
        for (int c = 1; c <= 10; c++) begin
            step();
            if (fs_if.ack) begin
                tmo_cyc = c;
                chk("tmo fs_dti", 32'(fs_if.dti), 32'h0);
                break;
            end
        end
        chk("tmo ack cycle", 32'(tmo_cyc), 32'd4);
        step();
        chk("tmo arb_err set", 32'(arb_err), 32'd1);
        chk("tmo mem_stb", 32'(mem_if.stb), 32'd0);
        fs_if.stb = 1'b0;
        step(); step(); step();
        chk("tmo arb_err sticky", 32'(arb_err), 32'd1);
        rst = 1'b1;
        step();
        chk("tmo arb_err rst", 32'(arb_err), 32'd0);
        rst = 1'b0;
        $display("tmo: ack cycle %0d", tmo_cyc);
`else
        tmo_cyc = 0;
        step();
        chk("no-tmo arb_err", 32'(arb_err), 32'(tmo_cyc));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
